// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-addressed memory accesses with byte enables, split misaligned accesses.
// Optional macro LSU_MISALIGN_TRAP_EN: accesses that would split return rsp_err instead of splitting.
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP} state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [2:0]          funct3_reg;
  logic [ADDR_W+1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         low_word_reg;

  logic                rsp_valid_reg, rsp_valid_next;
  logic [31:0]         rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                mem_en_reg, mem_en_next;
  logic                mem_we_reg, mem_we_next;
  logic [3:0]          mem_be_reg, mem_be_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]         mem_wdata_reg, mem_wdata_next;

  // Decode works on the incoming request while idle and on the latched one afterwards.
  logic                cur_we;
  logic [2:0]          cur_funct3;
  logic [ADDR_W+1:0]   cur_addr;
  logic [31:0]         cur_wdata;
  logic [1:0]          off;
  logic [1:0]          size;
  logic [3:0]          size_mask;
  logic [7:0]          be_full;
  logic [31:0]         wdata_masked;
  logic [63:0]         wdata_full;
  logic [ADDR_W-1:0]   word_addr;
  logic [ADDR_W-1:0]   word_addr_hi;
  logic                illegal;
  logic                split;
  logic                bad;
  logic [31:0]         load_raw;
  logic [31:0]         load_ext;
  logic                sign_ext;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign cur_we     = (state_reg == S_IDLE) ? req_we : we_reg;
  assign cur_funct3 = (state_reg == S_IDLE) ? req_funct3 : funct3_reg;
  assign cur_addr   = (state_reg == S_IDLE) ? req_addr[ADDR_W+1:0] : addr_reg;
  assign cur_wdata  = (state_reg == S_IDLE) ? req_wdata : wdata_reg;

  assign off          = cur_addr[1:0];
  assign size         = cur_funct3[1:0];
  assign size_mask    = (size == 2'b00) ? 4'b0001 : (size == 2'b01) ? 4'b0011 : 4'b1111;
  assign be_full      = {4'b0000, size_mask} << off;
  assign word_addr    = cur_addr[ADDR_W+1:2];
  assign word_addr_hi = word_addr + ADDR_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_masked[8*gi +: 8] = cur_wdata[8*gi +: 8] & {8{size_mask[gi]}};
    end
  endgenerate

  assign wdata_full = {32'b0, wdata_masked} << {off, 3'b000};

  assign illegal = cur_we ? (cur_funct3[2] | (size == 2'b11))
                          : ((size == 2'b11) | (cur_funct3 == 3'b110));
  assign split   = ((size == 2'b01) && (off == 2'b11)) || ((size == 2'b10) && (off != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = illegal | split;
`else
  assign bad = illegal;
`endif

  // Concatenating the two words lets one right shift align any split load.
  assign load_raw = 32'((split ? {mem_rdata, low_word_reg} : {32'b0, mem_rdata}) >> {off, 3'b000});
  assign sign_ext = ~cur_funct3[2];

  always_comb begin
    load_ext = load_raw;
    case (size)
      2'b00:   load_ext = {{24{sign_ext & load_raw[7]}}, load_raw[7:0]};
      2'b01:   load_ext = {{16{sign_ext & load_raw[15]}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_be_next    = '0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    unique case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next = S_ACC0;
          if (!bad) begin
            mem_en_next    = 1'b1;
            mem_we_next    = cur_we;
            mem_be_next    = be_full[3:0];
            mem_addr_next  = word_addr;
            mem_wdata_next = cur_we ? wdata_full[31:0] : 32'b0;
          end
        end
      end
      S_ACC0: begin
        if (bad) begin
          state_next     = S_RESP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end else if (split) begin
          state_next     = S_ACC1;
          mem_en_next    = 1'b1;
          mem_we_next    = cur_we;
          mem_be_next    = be_full[7:4];
          mem_addr_next  = word_addr_hi;
          mem_wdata_next = cur_we ? wdata_full[63:32] : 32'b0;
        end else if (cur_we) begin
          state_next     = S_RESP;
          rsp_valid_next = 1'b1;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_ACC1: begin
        if (cur_we) begin
          state_next     = S_RESP;
          rsp_valid_next = 1'b1;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        state_next     = S_RESP;
        rsp_valid_next = 1'b1;
        rsp_rdata_next = load_ext;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      low_word_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_be_reg    <= mem_be_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if (state_reg == S_IDLE && req_valid) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr[ADDR_W+1:0];
        wdata_reg  <= req_wdata;
      end
      // Low word of a split load arrives while the high word is being strobed.
      if (state_reg == S_ACC1) low_word_reg <= mem_rdata;
    end
  end

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
